// File: rtl/node_pkg.sv
`default_nettype none
// ============================================================================
// Module      : node_pkg
// Description : Shared codes and helpers for the node-1 MCU<->FPGA word bus.
// Revision    : 1.0 - initial release
// ============================================================================
package node_pkg;

  localparam logic [3:0] CLS_SCHED = 4'h0;
  localparam logic [3:0] CLS_PREQ  = 4'h1;
  localparam logic [3:0] CLS_PRESP = 4'h2;

  localparam logic [2:0] OP_SET_READY = 3'b001;
  localparam logic [2:0] OP_SET_WAIT  = 3'b010;
  localparam logic [2:0] OP_CLR_ALL   = 3'b011;
  localparam logic [2:0] OP_RUN       = 3'b100;

  localparam int NUM_TASKS = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_DISPATCH = 2'd2,
    ST_ACK      = 2'd3
  } rx_state_e;

  // Lowest-index ready task wins; 8'h00 when nothing is ready.
  function automatic logic [7:0] next_task_word(input logic [NUM_TASKS-1:0] ready);
    logic [7:0] w;
    w = 8'h00;
    for (int i = NUM_TASKS - 1; i >= 0; i--) begin
      if (ready[i]) w = {2'b00, 3'b100, 3'(i)};
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : First-word-fall-through FIFO; push is refused while full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/input_synchronizer_node1.sv
`default_nettype none
// ============================================================================
// Module      : input_synchronizer_node1
// Description : Node-1 bus receiver: strobe sync, command FSM, task table, request FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module input_synchronizer_node1
  import node_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_word,
  input  logic        in_strobe,
  output logic        in_ack,
  output logic [15:0] per0_data,
  output logic        per0_valid,
  input  logic        per0_ready,
  output logic [15:0] per1_data,
  output logic        per1_valid,
  input  logic        per1_ready,
  output logic [7:0]  task_ready,
  output logic [7:0]  next_task,
  output logic        err
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   armed_q, armed_d;
  logic                   prev_q, prev_d;
  rx_state_e              state_q, state_d;
  logic [15:0]            word_q, word_d;
  logic                   ack_q, ack_d;
  logic [7:0]             task_ready_q, task_ready_d;
  logic [7:0]             next_task_q, next_task_d;
  logic                   err_q, err_d;
  logic [1:0]             push, full, empty;
  logic                   strobe_sync, strobe_rise;

  // fill_q marks when the chain holds real samples, so the reset-cleared zeros cannot arm the detector.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], in_strobe};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    strobe_sync = sync_q[SYNC_STAGES-1];
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & ~strobe_sync);
    prev_d      = strobe_sync;
    strobe_rise = armed_q & strobe_sync & ~prev_q;
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    ack_d        = ack_q;
    task_ready_d = task_ready_q;
    err_d        = err_q;
    push         = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (strobe_rise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        word_d  = in_word;
        state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        case (word_q[11:8])
          CLS_SCHED: begin
            case (word_q[5:3])
              OP_SET_READY: task_ready_d[word_q[2:0]] = 1'b1;
              OP_SET_WAIT:  task_ready_d[word_q[2:0]] = 1'b0;
              OP_CLR_ALL:   task_ready_d = '0;
              default:      task_ready_d = task_ready_q;
            endcase
            state_d = ST_ACK;
          end
          CLS_PREQ: begin
            if (!full[word_q[12]]) begin
              push[word_q[12]] = 1'b1;
              state_d          = ST_ACK;
            end
          end
          CLS_PRESP: begin
            err_d   = 1'b1;
            state_d = ST_ACK;
          end
          default: begin
            err_d   = 1'b1;
            state_d = ST_ACK;
          end
        endcase
      end
      ST_ACK: begin
        ack_d   = ~ack_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    next_task_d = next_task_word(task_ready_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      prev_q       <= 1'b0;
      state_q      <= ST_IDLE;
      word_q       <= '0;
      ack_q        <= 1'b0;
      task_ready_q <= '0;
      next_task_q  <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      word_q       <= word_d;
      ack_q        <= ack_d;
      task_ready_q <= task_ready_d;
      next_task_q  <= next_task_d;
      err_q        <= err_d;
    end
  end

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[0]),
    .din   (word_q),
    .pop   (per0_ready),
    .dout  (per0_data),
    .full  (full[0]),
    .empty (empty[0])
  );

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[1]),
    .din   (word_q),
    .pop   (per1_ready),
    .dout  (per1_data),
    .full  (full[1]),
    .empty (empty[1])
  );

  assign per0_valid = ~empty[0];
  assign per1_valid = ~empty[1];
  assign in_ack     = ack_q;
  assign task_ready = task_ready_q;
  assign next_task  = next_task_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_input_synchronizer_node1.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_synchronizer_node1
// Description : Scoreboard bench for the node-1 input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_synchronizer_node1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_word;
  logic        in_strobe;
  logic        in_ack;
  logic [15:0] per0_data, per1_data;
  logic        per0_valid, per1_valid;
  logic        per0_ready, per1_ready;
  logic [7:0]  task_ready, next_task;
  logic        err;

  typedef struct packed {
    logic [7:0] tr;
    logic [7:0] nt;
    logic       er;
  } snap_t;

  snap_t       exp_q[$];
  logic [15:0] p0_q[$];
  logic [15:0] p1_q[$];
  int          errors = 0;
  int          checks = 0;
  int          ack_events = 0;
  logic        ack_prev;

  input_synchronizer_node1 #(.SYNC_STAGES(2), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_word    (in_word),
    .in_strobe  (in_strobe),
    .in_ack     (in_ack),
    .per0_data  (per0_data),
    .per0_valid (per0_valid),
    .per0_ready (per0_ready),
    .per1_data  (per1_data),
    .per1_valid (per1_valid),
    .per1_ready (per1_ready),
    .task_ready (task_ready),
    .next_task  (next_task),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: every ack toggle and every peripheral pop is compared against the queues.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      ack_prev = in_ack;
    end else begin
      if (in_ack !== ack_prev) begin
        snap_t e;
        ack_prev = in_ack;
        ack_events++;
        if (exp_q.size() == 0) fail_event("ack_unexpected");
        else begin
          e = exp_q.pop_front();
          check("ack_task_ready", {24'h0, task_ready}, {24'h0, e.tr});
          check("ack_next_task", {24'h0, next_task}, {24'h0, e.nt});
          check("ack_err", {31'h0, err}, {31'h0, e.er});
        end
      end
      if (per0_valid && per0_ready) begin
        if (p0_q.size() == 0) fail_event("per0_pop_unexpected");
        else check("per0_data", {16'h0, per0_data}, {16'h0, p0_q.pop_front()});
      end
      if (per1_valid && per1_ready) begin
        if (p1_q.size() == 0) fail_event("per1_pop_unexpected");
        else check("per1_data", {16'h0, per1_data}, {16'h0, p1_q.pop_front()});
      end
    end
  end

  // Issue one word, wait for its ack; exp_lat > 0 checks strobe-to-ack cycles.
  task automatic send(input logic [15:0] w, input snap_t e, input int exp_lat);
    logic a0;
    int   n;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    a0        = in_ack;
    in_word   = w;
    in_strobe = 1'b1;
    n         = 0;
    while (in_ack === a0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ack === a0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack for word %h", w);
    end else if (exp_lat > 0) begin
      check("ack_latency", n, exp_lat);
    end
    in_strobe = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, {31'h0, in_ack}, 32'h0);
    check({tag, "_p0v"}, {31'h0, per0_valid}, 32'h0);
    check({tag, "_p0d"}, {16'h0, per0_data}, 32'h0);
    check({tag, "_p1v"}, {31'h0, per1_valid}, 32'h0);
    check({tag, "_p1d"}, {16'h0, per1_data}, 32'h0);
    check({tag, "_tr"}, {24'h0, task_ready}, 32'h0);
    check({tag, "_nt"}, {24'h0, next_task}, 32'h0);
    check({tag, "_err"}, {31'h0, err}, 32'h0);
  endtask

  initial begin
    logic a0;
    int   n;
    int   ev0;
    rst        = 1'b1;
    in_word    = 16'h0000;
    in_strobe  = 1'b0;
    per0_ready = 1'b0;
    per1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");
    repeat (4) @(posedge clk);

    // Scheduler words, priority encoding and ignored op
    send(16'h000B, '{8'h08, 8'h23, 1'b0}, 6);
    send(16'h0018, '{8'h00, 8'h00, 1'b0}, 6);
    send(16'h0009, '{8'h02, 8'h21, 1'b0}, 0);
    send(16'h0021, '{8'h02, 8'h21, 1'b0}, 0);
    send(16'h0011, '{8'h00, 8'h00, 1'b0}, 0);
    send(16'h000F, '{8'h80, 8'h27, 1'b0}, 0);
    send(16'h0009, '{8'h82, 8'h21, 1'b0}, 0);
    send(16'h0018, '{8'h00, 8'h00, 1'b0}, 0);

    // Peripheral 1 request
    p1_q.push_back(16'h1155);
    send(16'h1155, '{8'h00, 8'h00, 1'b0}, 6);
    check("p1_valid", {31'h0, per1_valid}, 32'h1);
    check("p1_data", {16'h0, per1_data}, 32'h1155);
    check("p0_idle", {31'h0, per0_valid}, 32'h0);
    @(posedge clk);
    #1 per1_ready = 1'b1;
    @(posedge clk);
    #1 per1_ready = 1'b0;
    check("p1_drained", {31'h0, per1_valid}, 32'h0);

    // Fill FIFO 0, then stall the third request
    repeat (3) p0_q.push_back(16'h0100);
    send(16'h0100, '{8'h00, 8'h00, 1'b0}, 0);
    send(16'h0100, '{8'h00, 8'h00, 1'b0}, 0);
    @(posedge clk);
    #1;
    exp_q.push_back('{8'h00, 8'h00, 1'b0});
    a0        = in_ack;
    in_word   = 16'h0100;
    in_strobe = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("stall_no_ack", {31'h0, in_ack}, {31'h0, a0});
    check("stall_p0v", {31'h0, per0_valid}, 32'h1);
    per0_ready = 1'b1;
    @(posedge clk);
    #1 per0_ready = 1'b0;
    n = 0;
    while (in_ack === a0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_release_latency", n, 2);
    in_strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1 per0_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 per0_ready = 1'b0;
    check("p0_drained", {31'h0, per0_valid}, 32'h0);

    // Illegal class, then a legal word with err held
    send(16'h0200, '{8'h00, 8'h00, 1'b1}, 6);
    send(16'h000B, '{8'h08, 8'h23, 1'b1}, 0);
    send(16'h0700, '{8'h08, 8'h23, 1'b1}, 0);

    // Reset asserted while a word sits in DISPATCH
    p0_q.push_back(16'h0100);
    send(16'h0100, '{8'h08, 8'h23, 1'b1}, 0);
    @(posedge clk);
    #1;
    in_word   = 16'h1133;
    in_strobe = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    p0_q.delete();
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Strobe still high from before reset must not issue a command
    ev0 = ack_events;
    repeat (12) @(posedge clk);
    #1;
    check("held_strobe_ack", {31'h0, in_ack}, 32'h0);
    check("held_strobe_p1v", {31'h0, per1_valid}, 32'h0);
    check("held_strobe_events", ack_events - ev0, 0);
    in_strobe = 1'b0;
    repeat (4) @(posedge clk);
    ev0 = ack_events;
    send(16'h000B, '{8'h08, 8'h23, 1'b0}, 6);
    repeat (6) @(posedge clk);
    check("one_command", ack_events - ev0, 1);

    check("sb_ack_empty", exp_q.size(), 0);
    check("sb_p0_empty", p0_q.size(), 0);
    check("sb_p1_empty", p1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
